// File: rtl/weight_fetch_sequencer_if.sv
// weight_fetch_sequencer_if: command, read-master and PE-array signals of the weight fetch sequencer
interface weight_fetch_sequencer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 1024,
  parameter int LEN_W  = 12,
  parameter int REP_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] cfg_base;
  logic [LEN_W-1:0]  cfg_len;
  logic [ADDR_W-1:0] cfg_stride;
  logic [REP_W-1:0]  cfg_passes;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] pe_data;
  logic              pe_valid;
  logic              pe_ready;
  logic              pe_last;
  modport master (
    output start, cfg_base, cfg_len, cfg_stride, cfg_passes, rd_data, rd_valid, pe_ready,
    input  busy, done, rd_addr, rd_en, pe_data, pe_valid, pe_last
  );
  modport slave (
    input  start, cfg_base, cfg_len, cfg_stride, cfg_passes, rd_data, rd_valid, pe_ready,
    output busy, done, rd_addr, rd_en, pe_data, pe_valid, pe_last
  );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// weight_fetch_sequencer: walks base/stride/len/passes over the weight buffer and streams returned beats to the PE array
module weight_fetch_sequencer #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 1024,
  parameter int LEN_W  = 12,
  parameter int REP_W  = 8,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic rst_n,
  weight_fetch_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, stride_q, stride_d, addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, beat_q, beat_d;
  logic [REP_W-1:0]  passes_q, passes_d, pass_q, pass_d;
  logic [1:0]        quiet_q, quiet_d;
  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_q [DEPTH];
  logic              fifo_last_q [DEPTH];
  logic              push, pop, last_d, end_pass;
  assign pop = cnt_q != '0 && bus.pe_ready;
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    stride_d = stride_q;
    len_d    = len_q;
    passes_d = passes_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    pass_d   = pass_q;
    quiet_d  = quiet_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    push     = 1'b0;
    last_d   = 1'b0;
    end_pass = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        busy_d   = 1'b1;
        base_d   = bus.cfg_base;
        stride_d = bus.cfg_stride;
        len_d    = bus.cfg_len;
        passes_d = bus.cfg_passes == '0 ? REP_W'(1) : bus.cfg_passes;
        addr_d   = bus.cfg_base;
        beat_d   = '0;
        pass_d   = '0;
        state_d  = bus.cfg_len == '0 ? DONE : FETCH;
      end
      FETCH: if (bus.rd_valid) begin
        push     = 1'b1;
        end_pass = beat_q == len_q - 1'b1;
        last_d   = end_pass && pass_q == passes_q - 1'b1;
        addr_d   = end_pass ? base_q : addr_q + stride_q;
        beat_d   = end_pass ? '0 : beat_q + 1'b1;
        pass_d   = end_pass ? pass_q + 1'b1 : pass_q;
        quiet_d  = '0;
        state_d  = last_d ? DRAIN : FETCH;
      end
      DRAIN: begin
        // late beats from the read master are swallowed here; the quiet window covers its return latency
        quiet_d = bus.rd_valid ? '0 : (quiet_q == 2'd3 ? quiet_q : quiet_q + 1'b1);
        state_d = quiet_q == 2'd3 && cnt_q == '0 ? DONE : DRAIN;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    rd_en_d = state_d == FETCH && cnt_d <= CW'(DEPTH - 3);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      passes_q <= '0;
      addr_q   <= '0;
      beat_q   <= '0;
      pass_q   <= '0;
      quiet_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      passes_q <= passes_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      pass_q   <= pass_d;
      quiet_q  <= quiet_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q]      <= bus.rd_data;
      fifo_last_q[wr_ptr_q] <= last_d;
    end
  end
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_addr  = addr_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.pe_valid = cnt_q != '0;
  assign bus.pe_data  = bus.pe_valid ? fifo_q[rd_ptr_q] : '0;
  assign bus.pe_last  = bus.pe_valid && fifo_last_q[rd_ptr_q];
endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// tb_weight_fetch_sequencer: directed commands against a reference address/word model, checked every cycle
module tb_weight_fetch_sequencer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0, n_pass = 0;
  logic [16:0] exp_addr[$];
  logic [16:0] seen_addr[$];
  int total = 0, issue_idx = 0, pop_idx = 0, done_cnt = 0, occ = 0, max_occ = 0, stray_cnt = 0;
  bit rden_seen = 0, stray_en = 0, is_stray = 0;
  logic [3:0] sched = '0;

  weight_fetch_sequencer_if #(.ADDR_W(17), .DATA_W(1024), .LEN_W(12), .REP_W(8)) bus ();
  weight_fetch_sequencer #(.ADDR_W(17), .DATA_W(1024), .LEN_W(12), .REP_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [1023:0] mkword(int idx, logic [16:0] a);
    logic [31:0] w = {idx[14:0], a};
    return {32{w}};
  endfunction

  function automatic logic [16:0] get_seen(int i);
    return seen_addr.size() > i ? seen_addr[i] : 17'h0AAAA;
  endfunction

  // read master: one request in flight, data returned the cycle after rd_en is seen
  initial begin : master
    logic en_s, v_s;
    logic [16:0] a_s;
    bus.rd_valid = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      en_s = bus.rd_en;
      v_s = bus.rd_valid;
      a_s = bus.rd_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.rd_valid = 1'b0;
        is_stray = 1'b0;
        sched = '0;
      end else if (sched != '0) begin
        bus.rd_valid = sched[3];
        is_stray = sched[3];
        bus.rd_data = '1;
        sched = sched << 1;
      end else if (en_s && !v_s) begin
        if (issue_idx >= total) chk("extra_read", 64'(issue_idx), 64'(total - 1));
        else chk("rd_addr", 64'(a_s), 64'(exp_addr[issue_idx]));
        seen_addr.push_back(a_s);
        bus.rd_data = mkword(issue_idx, a_s);
        bus.rd_valid = 1'b1;
        is_stray = 1'b0;
        if (stray_en && issue_idx == total - 1) sched = 4'b0101;
        issue_idx++;
      end else begin
        bus.rd_valid = 1'b0;
        is_stray = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    int pu, po;
    if (!rst_n) occ = 0;
    else begin
      pu = (bus.rd_valid && !is_stray) ? 1 : 0;
      po = (bus.pe_valid && bus.pe_ready) ? 1 : 0;
      if (bus.rd_en) rden_seen = 1'b1;
      if (bus.rd_valid && is_stray) stray_cnt++;
      if (bus.done) begin
        done_cnt++;
        chk("busy_with_done", 64'(bus.busy), 64'(0));
      end
      chk("pe_valid_vs_occ", 64'(bus.pe_valid), 64'(occ != 0));
      chk("fifo_overflow", 64'(pu == 1 && occ >= DEPTH), 64'(0));
      if (occ >= DEPTH - 2) chk("rd_en_headroom", 64'(bus.rd_en), 64'(0));
      if (po == 1) begin
        if (pop_idx >= total) chk("extra_pe_word", 64'(pop_idx), 64'(total - 1));
        else begin
          n_chk++;
          if (bus.pe_data === mkword(pop_idx, exp_addr[pop_idx])) n_pass++;
          else $display("FAIL pe_data[%0d]: got %h expected %h", pop_idx, bus.pe_data[63:0],
                        mkword(pop_idx, exp_addr[pop_idx]) >> 0 & 1024'hFFFF_FFFF_FFFF_FFFF);
          chk("pe_last", 64'(bus.pe_last), 64'(pop_idx == total - 1));
        end
        pop_idx++;
      end
      occ = occ + pu - po;
      if (occ > max_occ) max_occ = occ;
    end
  end

  task automatic start_cmd(input logic [16:0] base, input int len, input logic [16:0] stride,
                           input int passes, input bit stray);
    int np = (passes == 0) ? 1 : passes;
    exp_addr.delete();
    seen_addr.delete();
    for (int p = 0; p < np; p++)
      for (int i = 0; i < len; i++) exp_addr.push_back(base + 17'(i) * stride);
    total = len * np;
    issue_idx = 0;
    pop_idx = 0;
    done_cnt = 0;
    rden_seen = 1'b0;
    stray_cnt = 0;
    stray_en = stray;
    bus.cfg_base = base;
    bus.cfg_len = 12'(len);
    bus.cfg_stride = stride;
    bus.cfg_passes = 8'(passes);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'(1));
  endtask

  task automatic finish_cmd(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    chk({tag, "_pe_words"}, 64'(pop_idx), 64'(total));
    chk({tag, "_reads"}, 64'(issue_idx), 64'(total));
    chk({tag, "_idle_valid"}, 64'(bus.pe_valid), 64'(0));
    chk({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.cfg_base = '0;
    bus.cfg_len = '0;
    bus.cfg_stride = '0;
    bus.cfg_passes = '0;
    bus.pe_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
    chk("rst_pe_valid", 64'(bus.pe_valid), 64'(0));
    chk("rst_pe_last", 64'(bus.pe_last), 64'(0));
    chk("rst_rd_addr", 64'(bus.rd_addr), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    start_cmd(17'h100, 4, 17'd1, 1, 1'b0);
    finish_cmd("single");
    chk("single_addr0", 64'(get_seen(0)), 64'h100);
    chk("single_addr3", 64'(get_seen(3)), 64'h103);

    start_cmd(17'h10, 3, 17'd2, 3, 1'b0);
    finish_cmd("multi");
    chk("multi_addr2", 64'(get_seen(2)), 64'h14);
    chk("multi_addr3", 64'(get_seen(3)), 64'h10);
    chk("multi_addr8", 64'(get_seen(8)), 64'h14);
    chk("multi_words", 64'(pop_idx), 64'd9);

    bus.pe_ready = 1'b0;
    max_occ = 0;
    start_cmd(17'h40, 16, 17'd3, 1, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    chk("bp_max_occ", 64'(max_occ), 64'd2);
    chk("bp_rd_en_low", 64'(bus.rd_en), 64'(0));
    chk("bp_pe_words_held", 64'(pop_idx), 64'(0));
    bus.pe_ready = 1'b1;
    finish_cmd("backpressure");

    start_cmd(17'h55, 0, 17'd1, 1, 1'b0);
    chk("len0_done_c1", 64'(bus.done), 64'(0));
    @(posedge clk);
    #1;
    chk("len0_done_c2", 64'(bus.done), 64'(1));
    chk("len0_busy_c2", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    chk("len0_done_c3", 64'(bus.done), 64'(0));
    chk("len0_done_cnt", 64'(done_cnt), 64'(1));
    chk("len0_no_rd_en", 64'(rden_seen), 64'(0));

    start_cmd(17'h200, 3, 17'd1, 0, 1'b0);
    finish_cmd("passes0");
    chk("passes0_words", 64'(pop_idx), 64'd3);

    start_cmd(17'h1FFFF, 2, 17'd1, 1, 1'b0);
    finish_cmd("wrap");
    chk("wrap_addr0", 64'(get_seen(0)), 64'h1FFFF);
    chk("wrap_addr1", 64'(get_seen(1)), 64'h00000);

    start_cmd(17'h300, 5, 17'd1, 1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.cfg_base = 17'h0;
    bus.cfg_len = 12'd9;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    finish_cmd("stray");
    chk("stray_injected", 64'(stray_cnt), 64'd2);
    chk("stray_words", 64'(pop_idx), 64'd5);

    start_cmd(17'h400, 10, 17'd1, 1, 1'b0);
    n = 0;
    while (pop_idx < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", 64'(pop_idx >= 5), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rstm_busy", 64'(bus.busy), 64'(0));
    chk("rstm_done", 64'(bus.done), 64'(0));
    chk("rstm_rd_en", 64'(bus.rd_en), 64'(0));
    chk("rstm_pe_valid", 64'(bus.pe_valid), 64'(0));
    chk("rstm_pe_last", 64'(bus.pe_last), 64'(0));
    chk("rstm_rd_addr", 64'(bus.rd_addr), 64'(0));
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstm_no_done", 64'(done_cnt), 64'(0));
    chk("rstm_idle_busy", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    start_cmd(17'h500, 6, 17'd2, 2, 1'b0);
    finish_cmd("after_rst");
    chk("after_rst_addr6", 64'(get_seen(6)), 64'h500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/weight_fetch_sequencer.md
Name: weight_fetch_sequencer

Overview:
- Sequences the on-chip weight-buffer read master.
- Takes a start command with base address, word count, address stride and pass count.
- Drives the read master's address and read-enable inputs and collects the returned 1024-bit beats in a small FIFO.
- Delivers the beats to the PE array over a valid/ready handshake with a last-beat marker.

Parameters:
ADDR_W, 17, weight-buffer word address width
DATA_W, 1024, weight word width
LEN_W, 12, width of the words-per-pass count
REP_W, 8, width of the pass count
DEPTH, 4, output FIFO depth in words; minimum 4, power of two

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle command pulse; sampled only in IDLE
cfg_base  in  ADDR_W  first word address of each pass
cfg_len  in  LEN_W  words per pass
cfg_stride  in  ADDR_W  address increment per word
cfg_passes  in  REP_W  number of passes over the same words; 0 is treated as 1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the command completes
rd_addr  out  ADDR_W  to read master addr_read_input
rd_en  out  1  to read master read_en_input
rd_data  in  DATA_W  from read master data_read
rd_valid  in  1  from read master data_valid
pe_data  out  DATA_W  FIFO head word
pe_valid  out  1  FIFO non-empty
pe_ready  in  1  PE array accepts pe_data when pe_valid && pe_ready
pe_last  out  1  qualifies pe_data as the final word of the command

Behaviour:
- Reset values: busy, done, rd_en, pe_valid, pe_last = 0; rd_addr = 0; FIFO empty; state IDLE.
- Reset asserted mid-operation: everything returns to reset values on the next edge with no done pulse; later rd_valid pulses are ignored until the next start.
- State IDLE:
  - start with cfg_len == 0: go to DONE; no reads are issued.
  - Otherwise latch the config, rd_addr = cfg_base, beat counter = 0, pass counter = 0, go to FETCH.
- State FETCH:
  - rd_en = 1 while FIFO occupancy <= DEPTH-3. The read master may return up to 2 beats after rd_en falls; this headroom guarantees no overflow.
  - rd_addr is held stable until a beat is received.
  - On each rd_valid: push rd_data into the FIFO and increment the beat counter.
  - On each rd_valid, rd_addr advances by cfg_stride, modulo 2^ADDR_W so it wraps silently.
  - End of pass (beat counter reaches cfg_len): rd_addr reloads cfg_base, beat counter clears and the pass counter increments.
  - The FIFO entry written for the final beat of the final pass carries last = 1.
  - After that final beat: rd_en = 0, go to DRAIN.
- State DRAIN:
  - rd_valid pulses are discarded and never pushed to the FIFO.
  - Leave when 3 consecutive cycles pass with no rd_valid and the FIFO is empty; go to DONE.
- State DONE: done = 1 for one cycle, then IDLE. busy falls in the same cycle done is high.
- FIFO behaviour:
  - Simultaneous push and pop is allowed and keeps occupancy unchanged.
  - Pop on empty is impossible (pe_valid = 0).
  - A push when full is a design error; the bench asserts it never occurs.
- pe_valid and pe_data come from registered FIFO state; there is no combinational path from pe_ready to pe_valid.
- start in any state other than IDLE is ignored.

Test Plan:
- Single pass, pe_ready held 1: base=0x100, len=4, stride=1, passes=1. Addresses 0x100..0x103 are read. PE gets 4 words in order, pe_last only on the 4th. One done pulse. busy drops with done.
- Multi-pass with stride: base=0x10, len=3, stride=2, passes=3. Address sequence is 0x10,0x12,0x14 repeated 3 times. 9 PE words; pe_last only on the 9th.
- Backpressure: len=16, pe_ready low for 20 cycles. rd_en falls once occupancy reaches DEPTH-2. FIFO never overflows. After ready returns, all 16 words are delivered in order with no loss or duplicates.
- Edge configs:
  - len=0 gives done 2 cycles after start with rd_en never high.
  - passes=0 behaves as passes=1.
  - base=0x1FFFF, stride=1, len=2 reads 0x1FFFF then 0x00000.
- Stray beats: inject 2 extra rd_valid pulses after the final beat. They are dropped and pe_valid stays 0. start pulsed while busy has no effect.
- Reset mid-command: assert rst_n=0 after 5 of 10 words. All outputs are 0 immediately, with no done pulse. A new start afterwards completes normally.
